hs32_prefetch: RTL and testbench

- Parametrised next-generation instruction prefetcher for the HS32 core.
- Sits between the memory arbiter and decode.
- Issues pipelined word fetches with up to MAX_OUTSTANDING requests in flight, and buffers returned instructions in a 2**DEPTH_LOG2 FIFO.
- Presents instructions and their PC to decode through a valid/ready handshake; flush redirects the PC and drops stale in-flight data.

---
 rtl/hs32_pkg.sv | 15 +
 rtl/hs32_sync_fifo.sv | 57 +++++
 rtl/hs32_prefetch.sv | 156 +++++++++++++++
 tb/tb_hs32_prefetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_pkg.sv
// Shared HS32 constants and the prefetch FIFO entry layout.
package hs32_pkg;

  localparam int HS32_XLEN       = 32;
  localparam int HS32_INST_BYTES = 4;

  // One buffered instruction: its fetch address and the returned word.
  typedef struct packed {
    logic [HS32_XLEN-1:0] pc;
    logic [HS32_XLEN-1:0] inst;
  } hs32_fifo_entry_t;

  localparam int HS32_FIFO_ENTRY_W = $bits(hs32_fifo_entry_t);

endpackage

// File: rtl/hs32_sync_fifo.sv
// Single-clock FIFO with 2**DEPTH_LOG2 entries, extra-MSB pointers and a
// synchronous clear. The head word is visible combinationally on rdata so
// the consumer can load it in the same cycle it pops.
module hs32_sync_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr_reg;
  logic [DEPTH_LOG2:0] rptr_reg;
  logic                wr_en;
  logic                rd_en;

  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[DEPTH_LOG2] != rptr_reg[DEPTH_LOG2]) &&
                 (wptr_reg[DEPTH_LOG2-1:0] == rptr_reg[DEPTH_LOG2-1:0]);
  assign fill  = wptr_reg - rptr_reg;
  assign rdata = mem[rptr_reg[DEPTH_LOG2-1:0]];

  // A push into a full FIFO is fine when the head leaves in the same cycle;
  // a pop from an empty FIFO is ignored.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_reg[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  // Pointer update; clear empties the FIFO and wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (wr_en) wptr_reg <= wptr_reg + 1'b1;
      if (rd_en) rptr_reg <= rptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hs32_prefetch.sv
// HS32 instruction prefetcher: pipelined word fetches with a credit limit,
// a return FIFO, and a valid/ready output register towards decode.
// Optional macro HS32_PREFETCH_BYPASS_EN lets an ack load the output
// register directly when the FIFO is empty, saving one cycle of latency.
module hs32_prefetch
  import hs32_pkg::*;
#(
  parameter int          DEPTH_LOG2      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic        stbm,
  input  logic        stlm,
  input  logic [31:0] dtr,
  input  logic        ackm,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        reqd,
  input  logic        rdyd,
  input  logic [31:0] newpc,
  input  logic        flush
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int DROP_W = 8;
  localparam int SUM_W  = 8;
  localparam logic [CNT_W-1:0] MAX_OUT    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0] FIFO_DEPTH = SUM_W'(1 << DEPTH_LOG2);
  localparam logic [31:0]      INST_STEP  = 32'(HS32_INST_BYTES);

  logic [31:0]       pc_reg, pc_next;
  logic [31:0]       rpc_reg, rpc_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [DROP_W-1:0] drop_reg, drop_next;
  logic              reqd_reg, reqd_next;
  logic [31:0]       instd_reg, instd_next;
  logic [31:0]       pcd_reg, pcd_next;

  logic              accept;
  logic              ack_keep;
  logic              ack_drop;
  logic              out_free;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DEPTH_LOG2:0] fifo_fill;
  logic [SUM_W-1:0]  credit_used;
  hs32_fifo_entry_t  push_entry;
  hs32_fifo_entry_t  fifo_head;

  // Credits cover FIFO contents, requests in flight and the output register,
  // so every accepted request has a guaranteed slot when its ack returns.
  assign credit_used = SUM_W'(fifo_fill) + SUM_W'(outstanding_reg) + SUM_W'(reqd_reg);
  assign stbm  = !reset && !flush && (outstanding_reg < MAX_OUT) && (credit_used < FIFO_DEPTH);
  assign addr  = pc_reg;
  assign reqd  = reqd_reg;
  assign instd = instd_reg;
  assign pcd   = pcd_reg;

  assign accept   = stbm && !stlm;
  assign ack_keep = ackm && (drop_reg == '0);
  assign ack_drop = ackm && (drop_reg != '0);
  assign out_free = !reqd_reg || rdyd;

`ifdef HS32_PREFETCH_BYPASS_EN
  assign bypass = ack_keep && fifo_empty && out_free && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push_entry = '{pc: rpc_reg, inst: dtr};
  assign fifo_push  = ack_keep && !bypass && !flush && (!fifo_full || fifo_pop);
  assign fifo_pop   = !flush && !fifo_empty && out_free;

  hs32_sync_fifo #(
    .WIDTH      (HS32_FIFO_ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fifo_fill)
  );

  // Next-state for issue PC, return PC, credit/drop counters and decode output.
  always_comb begin
    pc_next          = pc_reg;
    rpc_next         = rpc_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    reqd_next        = reqd_reg;
    instd_next       = instd_reg;
    pcd_next         = pcd_reg;

    if (flush) begin
      pc_next          = newpc;
      rpc_next         = newpc;
      outstanding_next = '0;
      // Everything still in flight after this edge must be discarded: earlier
      // drops, current outstanding and any same-cycle accept, less the ack
      // consumed (and discarded) in this very cycle.
      drop_next        = drop_reg + DROP_W'(outstanding_reg) + DROP_W'(accept) - DROP_W'(ackm);
      reqd_next        = 1'b0;
    end else begin
      if (accept)   pc_next  = pc_reg + INST_STEP;
      if (ack_keep) rpc_next = rpc_reg + INST_STEP;
      if (ack_drop) drop_next = drop_reg - DROP_W'(1);
      outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(ack_keep);

      if (fifo_pop) begin
        reqd_next  = 1'b1;
        instd_next = fifo_head.inst;
        pcd_next   = fifo_head.pc;
      end else if (bypass) begin
        reqd_next  = 1'b1;
        instd_next = dtr;
        pcd_next   = rpc_reg;
      end else if (rdyd) begin
        reqd_next  = 1'b0;
      end
    end
  end

  // State registers; reset beats flush and also clears pending drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      rpc_reg         <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      reqd_reg        <= 1'b0;
      instd_reg       <= '0;
      pcd_reg         <= '0;
    end else begin
      pc_reg          <= pc_next;
      rpc_reg         <= rpc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      reqd_reg        <= reqd_next;
      instd_reg       <= instd_next;
      pcd_reg         <= pcd_next;
    end
  end

endmodule

// File: tb/tb_hs32_prefetch.sv
// Scoreboard bench for hs32_prefetch: a memory/arbiter model answers
// accepted requests, the monitor pushes the expected {pc, word} per issued
// address and compares it against every decode transfer.
module tb_hs32_prefetch;
  import hs32_pkg::*;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stbm, stlm, ackm, reqd, rdyd, flush;
  logic [31:0] addr, dtr, instd, pcd, newpc;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int xfer_count = 0;
  logic ack_hold = 1'b0;
  logic chk_outst = 1'b0;
  logic [31:0] exp_issue_pc = RESET_PC_TB;
  hs32_fifo_entry_t sb[$];
  logic [31:0] pending[$];

  hs32_prefetch #(
    .DEPTH_LOG2(2), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC_TB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .stbm(stbm), .stlm(stlm),
    .dtr(dtr), .ackm(ackm), .instd(instd), .pcd(pcd), .reqd(reqd),
    .rdyd(rdyd), .newpc(newpc), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // Arbiter/memory model: acks each accepted request one cycle later, in order.
  initial begin
    ackm = 1'b0;
    dtr  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        pending.delete();
        ackm = 1'b0;
        dtr  = '0;
      end else if (!ack_hold && pending.size() > 0) begin
        dtr  = mem_word(pending.pop_front());
        ackm = 1'b1;
      end else begin
        ackm = 1'b0;
        dtr  = '0;
      end
    end
  end

  // Monitor: checks issue addresses, records expectations, scores transfers.
  initial begin
    hs32_fifo_entry_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        exp_issue_pc = RESET_PC_TB;
        chk("stbm_in_reset", 32'(stbm), 32'd0);
      end else if (flush) begin
        sb.delete();
        exp_issue_pc = newpc;
        chk("stbm_in_flush", 32'(stbm), 32'd0);
      end else begin
        if (chk_outst)
          chk("outstanding_le_2", 32'((pending.size() + int'(ackm)) <= 2), 32'd1);
        if (reqd && rdyd) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected: got pcd 0x%08h, expected no transfer", pcd);
          end else begin
            e = sb.pop_front();
            chk("xfer_pcd", pcd, e.pc);
            chk("xfer_instd", instd, e.inst);
          end
          xfer_count++;
        end
        if (stbm && !stlm) begin
          chk("issue_addr", addr, exp_issue_pc);
          e.pc   = exp_issue_pc;
          e.inst = mem_word(exp_issue_pc);
          sb.push_back(e);
          pending.push_back(addr);
          exp_issue_pc = exp_issue_pc + 32'd4;
          acc_count++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    int a0, x0, n, lat, exp_lat;
    logic seen;
    reset = 1'b1; flush = 1'b0; newpc = '0; rdyd = 1'b0; stlm = 1'b0;
    cyc(3);
    chk("rst_stbm", 32'(stbm), 32'd0);
    chk("rst_reqd", 32'(reqd), 32'd0);
    chk("rst_instd", instd, 32'd0);
    chk("rst_pcd", pcd, 32'd0);
    chk("rst_addr", addr, RESET_PC_TB);

    // 1: free-running fetch with decode always ready.
    rdyd = 1'b1; reset = 1'b0; chk_outst = 1'b1;
    x0 = xfer_count;
    cyc(30);
    chk_outst = 1'b0;
    chk("t1_xfers_ge15", 32'((xfer_count - x0) >= 15), 32'd1);

    // 2: decode stalled; exactly four words buffered, then drain.
    rdyd = 1'b0;
    do_reset();
    a0 = acc_count;
    cyc(20);
    chk("t2_accepts", 32'(acc_count - a0), 32'd4);
    chk("t2_stbm_low", 32'(stbm), 32'd0);
    chk("t2_reqd", 32'(reqd), 32'd1);
    chk("t2_pcd_held", pcd, 32'h0);
    chk("t2_instd_held", instd, mem_word(32'h0));
    x0 = xfer_count;
    rdyd = 1'b1;
    cyc(20);
    chk("t2_drain_ge8", 32'((xfer_count - x0) >= 8), 32'd1);

    // 3: arbiter stall on the request at 0x8.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (stbm && addr == 32'h8) seen = 1'b1;
      else cyc(1);
    end
    chk("t3_reach_8", 32'(seen), 32'd1);
    stlm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stbm_held", 32'(stbm), 32'd1);
      chk("t3_addr_held", addr, 32'h8);
      cyc(1);
    end
    stlm = 1'b0;
    cyc(15);

    // 4: flush with two requests outstanding; both late acks dropped.
    ack_hold = 1'b1;
    do_reset();
    a0 = acc_count;
    cyc(6);
    chk("t4_accepts", 32'(acc_count - a0), 32'd2);
    chk("t4_stbm_credit", 32'(stbm), 32'd0);
    flush = 1'b1; newpc = 32'h100; ack_hold = 1'b0;
    x0 = xfer_count;
    cyc(1);
    flush = 1'b0;
    chk("t4_reqd_cleared", 32'(reqd), 32'd0);
    cyc(25);
    chk("t4_xfers_ge5", 32'((xfer_count - x0) >= 5), 32'd1);

    // 5: flush in the same cycle as an ack.
    ack_hold = 1'b1;
    do_reset();
    cyc(6);
    ack_hold = 1'b0;
    cyc(1);
    chk("t5_ack_present", 32'(ackm), 32'd1);
    flush = 1'b1; newpc = 32'h200;
    x0 = xfer_count;
    cyc(1);
    flush = 1'b0;
    chk("t5_fifo_empty_a", 32'(reqd), 32'd0);
    cyc(1);
    chk("t5_fifo_empty_b", 32'(reqd), 32'd0);
    cyc(25);
    chk("t5_xfers_ge5", 32'((xfer_count - x0) >= 5), 32'd1);

    // 6: reset mid-burst, then first-ack-to-reqd latency.
    do_reset();
    cyc(8);
    reset = 1'b1;
    cyc(1);
    chk("t6_stbm", 32'(stbm), 32'd0);
    chk("t6_reqd", 32'(reqd), 32'd0);
    chk("t6_instd", instd, 32'd0);
    chk("t6_pcd", pcd, 32'd0);
    chk("t6_addr", addr, RESET_PC_TB);
    reset = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ackm) seen = 1'b1;
    end
    chk("t6_first_ack", 32'(seen), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!reqd && lat < 8);
`ifdef HS32_PREFETCH_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    chk("t6_latency", 32'(lat), 32'(exp_lat));
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
